// File: rtl/ysyx_23060025_lsu_pkg.sv
// Shared definitions for the LSU stage: access type codes, FSM states and
// the width of the forward bus returned to decode.
package ysyx_23060025_lsu_pkg;

    localparam int LS_TO_DS_FORWARD_BUS = 39;

    typedef enum logic [2:0] {
        LD_NONE = 3'd0,
        LD_LB   = 3'd1,
        LD_LH   = 3'd2,
        LD_LW   = 3'd3,
        LD_LBU  = 3'd4,
        LD_LHU  = 3'd5
    } load_type_e;

    typedef enum logic [1:0] {
        ST_NONE = 2'd0,
        ST_SB   = 2'd1,
        ST_SH   = 2'd2,
        ST_SW   = 2'd3
    } store_type_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } lsu_state_e;

endpackage

// File: rtl/ysyx_23060025_lsu_align.sv
// Combinational byte-lane logic: store data/strobe placement and load
// extraction with sign or zero extension. Misaligned accesses are not trapped.
module ysyx_23060025_lsu_align
    import ysyx_23060025_lsu_pkg::*;
#(
    parameter int DATA_LEN = 32
) (
    input  logic [1:0]          addr_lo_i,
    input  logic [2:0]          load_type_i,
    input  logic [1:0]          store_type_i,
    input  logic [DATA_LEN-1:0] store_data_i,
    input  logic [DATA_LEN-1:0] rdata_i,
    output logic [DATA_LEN-1:0] wdata_o,
    output logic [3:0]          wstrb_o,
    output logic [DATA_LEN-1:0] load_data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        wdata_o = store_data_i;
        wstrb_o = 4'b0000;
        case (store_type_i)
            ST_SB: begin
                wstrb_o = 4'b0001 << addr_lo_i;
                wdata_o = {4{store_data_i[7:0]}};
            end
            ST_SH: begin
                wstrb_o = 4'b0011 << {addr_lo_i[1], 1'b0};
                wdata_o = {2{store_data_i[15:0]}};
            end
            ST_SW:   wstrb_o = 4'hF;
            default: ;
        endcase
    end

    always_comb begin
        case (addr_lo_i)
            2'd0:    byte_sel = rdata_i[7:0];
            2'd1:    byte_sel = rdata_i[15:8];
            2'd2:    byte_sel = rdata_i[23:16];
            default: byte_sel = rdata_i[31:24];
        endcase
        half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    end

    always_comb begin
        load_data_o = rdata_i;
        case (load_type_i)
            LD_LB:   load_data_o = {{(DATA_LEN-8){byte_sel[7]}}, byte_sel};
            LD_LBU:  load_data_o = {{(DATA_LEN-8){1'b0}}, byte_sel};
            LD_LH:   load_data_o = {{(DATA_LEN-16){half_sel[15]}}, half_sel};
            LD_LHU:  load_data_o = {{(DATA_LEN-16){1'b0}}, half_sel};
            default: ;
        endcase
    end

endmodule

// File: rtl/ysyx_23060025_lsu_stage.sv
// LSU pipeline stage: latches EX results, runs one memory transaction per
// memory op through a REQ/WAIT/DONE handshake FSM, and offers results to WB.
module ysyx_23060025_lsu_stage
    import ysyx_23060025_lsu_pkg::*;
#(
    parameter int DATA_LEN = 32
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            es_to_lsu_valid_i,
    output logic                            lsu_allowin_o,
    input  logic [DATA_LEN-1:0]             alu_result_i,
    input  logic [DATA_LEN-1:0]             mem_wdata_i,
    input  logic [2:0]                      load_type_i,
    input  logic [1:0]                      store_type_i,
    input  logic                            wd_i,
    input  logic [4:0]                      wreg_i,
    input  logic [31:0]                     pc_i,
    output logic                            mem_req_valid_o,
    input  logic                            mem_req_ready_i,
    output logic                            mem_req_wen_o,
    output logic [31:0]                     mem_req_addr_o,
    output logic [DATA_LEN-1:0]             mem_req_wdata_o,
    output logic [3:0]                      mem_req_wstrb_o,
    input  logic                            mem_resp_valid_i,
    input  logic [DATA_LEN-1:0]             mem_resp_rdata_i,
    output logic                            lsu_to_ws_valid_o,
    input  logic                            ws_allowin_i,
    output logic                            ws_wd_o,
    output logic [4:0]                      ws_wreg_o,
    output logic [DATA_LEN-1:0]             ws_wdata_o,
    output logic [31:0]                     ws_pc_o,
    output logic [LS_TO_DS_FORWARD_BUS-1:0] ls_to_ds_forward_bus_o
);

    logic                ls_valid_q;
    lsu_state_e          state_q;
    logic [DATA_LEN-1:0] alu_result_q;
    logic [DATA_LEN-1:0] mem_wdata_q;
    logic [2:0]          load_type_q;
    logic [1:0]          store_type_q;
    logic                wd_q;
    logic [4:0]          wreg_q;
    logic [31:0]         pc_q;
    logic [DATA_LEN-1:0] rdata_q;

    logic                is_mem_in, is_load_q, is_mem_q, ready_go, accept;
    logic [DATA_LEN-1:0] load_data;

    assign is_mem_in = (load_type_i != 3'd0) || (store_type_i != 2'd0);
    assign is_load_q = (load_type_q != 3'd0);
    assign is_mem_q  = is_load_q || (store_type_q != 2'd0);

    assign ready_go          = (state_q == S_DONE) || ((state_q == S_IDLE) && !is_mem_q);
    assign lsu_allowin_o     = !ls_valid_q || (ready_go && ws_allowin_i);
    assign lsu_to_ws_valid_o = ls_valid_q && ready_go;
    assign accept            = es_to_lsu_valid_i && lsu_allowin_o;

    // Any handshake that frees the stage also decides the next state, so a
    // new memory op can go straight from DONE (or IDLE) into REQ.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ls_valid_q   <= 1'b0;
            state_q      <= S_IDLE;
            alu_result_q <= '0;
            mem_wdata_q  <= '0;
            load_type_q  <= 3'd0;
            store_type_q <= 2'd0;
            wd_q         <= 1'b0;
            wreg_q       <= 5'd0;
            pc_q         <= 32'd0;
            rdata_q      <= '0;
        end else begin
            if (lsu_allowin_o) begin
                ls_valid_q <= es_to_lsu_valid_i;
                state_q    <= (accept && is_mem_in) ? S_REQ : S_IDLE;
            end else begin
                case (state_q)
                    S_REQ:  if (mem_req_ready_i) state_q <= S_WAIT;
                    S_WAIT: if (mem_resp_valid_i) begin
                        rdata_q <= mem_resp_rdata_i;
                        state_q <= S_DONE;
                    end
                    default: ;
                endcase
            end
            if (accept) begin
                alu_result_q <= alu_result_i;
                mem_wdata_q  <= mem_wdata_i;
                load_type_q  <= load_type_i;
                store_type_q <= store_type_i;
                wd_q         <= wd_i;
                wreg_q       <= wreg_i;
                pc_q         <= pc_i;
            end
        end
    end

    ysyx_23060025_lsu_align #(.DATA_LEN(DATA_LEN)) u_align (
        .addr_lo_i    (alu_result_q[1:0]),
        .load_type_i  (load_type_q),
        .store_type_i (store_type_q),
        .store_data_i (mem_wdata_q),
        .rdata_i      (rdata_q),
        .wdata_o      (mem_req_wdata_o),
        .wstrb_o      (mem_req_wstrb_o),
        .load_data_o  (load_data)
    );

    assign mem_req_valid_o = ls_valid_q && (state_q == S_REQ);
    assign mem_req_wen_o   = (store_type_q != 2'd0);
    assign mem_req_addr_o  = {alu_result_q[31:2], 2'b00};

    assign ws_wd_o    = wd_q;
    assign ws_wreg_o  = wreg_q;
    assign ws_pc_o    = pc_q;
    assign ws_wdata_o = is_load_q ? load_data : alu_result_q;

    assign ls_to_ds_forward_bus_o = {
        ls_valid_q && is_load_q && (state_q != S_DONE),
        wd_q && (wreg_q != 5'd0) && ls_valid_q,
        wreg_q,
        ws_wdata_o
    };

endmodule

// File: tb/tb_ysyx_23060025_lsu_stage.sv
// Directed bench for the LSU stage; WB results are checked against a
// scoreboard queue filled when each instruction is offered.
module tb_ysyx_23060025_lsu_stage;
    import ysyx_23060025_lsu_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        es_to_lsu_valid_i = 1'b0;
    logic        lsu_allowin_o;
    logic [31:0] alu_result_i = '0;
    logic [31:0] mem_wdata_i = '0;
    logic [2:0]  load_type_i = '0;
    logic [1:0]  store_type_i = '0;
    logic        wd_i = 1'b0;
    logic [4:0]  wreg_i = '0;
    logic [31:0] pc_i = '0;
    logic        mem_req_valid_o;
    logic        mem_req_ready_i = 1'b1;
    logic        mem_req_wen_o;
    logic [31:0] mem_req_addr_o;
    logic [31:0] mem_req_wdata_o;
    logic [3:0]  mem_req_wstrb_o;
    logic        mem_resp_valid_i = 1'b0;
    logic [31:0] mem_resp_rdata_i = '0;
    logic        lsu_to_ws_valid_o;
    logic        ws_allowin_i = 1'b1;
    logic        ws_wd_o;
    logic [4:0]  ws_wreg_o;
    logic [31:0] ws_wdata_o;
    logic [31:0] ws_pc_o;
    logic [38:0] ls_to_ds_forward_bus_o;

    ysyx_23060025_lsu_stage #(.DATA_LEN(32)) dut (
        .clock(clock), .reset(reset),
        .es_to_lsu_valid_i(es_to_lsu_valid_i), .lsu_allowin_o(lsu_allowin_o),
        .alu_result_i(alu_result_i), .mem_wdata_i(mem_wdata_i),
        .load_type_i(load_type_i), .store_type_i(store_type_i),
        .wd_i(wd_i), .wreg_i(wreg_i), .pc_i(pc_i),
        .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
        .mem_req_wen_o(mem_req_wen_o), .mem_req_addr_o(mem_req_addr_o),
        .mem_req_wdata_o(mem_req_wdata_o), .mem_req_wstrb_o(mem_req_wstrb_o),
        .mem_resp_valid_i(mem_resp_valid_i), .mem_resp_rdata_i(mem_resp_rdata_i),
        .lsu_to_ws_valid_o(lsu_to_ws_valid_o), .ws_allowin_i(ws_allowin_i),
        .ws_wd_o(ws_wd_o), .ws_wreg_o(ws_wreg_o), .ws_wdata_o(ws_wdata_o),
        .ws_pc_o(ws_pc_o), .ls_to_ds_forward_bus_o(ls_to_ds_forward_bus_o)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] wdata;
        logic [4:0]  wreg;
        logic [31:0] pc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [2:0] lt, input logic [1:0] st, input logic [31:0] a,
                         input logic [31:0] d, input logic w, input logic [4:0] r,
                         input logic [31:0] pc);
        load_type_i       = lt;
        store_type_i      = st;
        alu_result_i      = a;
        mem_wdata_i       = d;
        wd_i              = w;
        wreg_i            = r;
        pc_i              = pc;
        es_to_lsu_valid_i = 1'b1;
    endtask

    task automatic push(input logic [31:0] wd, input logic [4:0] r, input logic [31:0] pc);
        exp_t e;
        e.wdata = wd;
        e.wreg  = r;
        e.pc    = pc;
        sb.push_back(e);
    endtask

    // Holds the offer until the stage accepts it, then withdraws it.
    task automatic wait_accept(input string tag);
        int n = 0;
        while (!lsu_allowin_o && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_accept"}, 64'(n < 20), 64'd1);
        tick();
        es_to_lsu_valid_i = 1'b0;
    endtask

    // WB side: every handshake retires the oldest expected result.
    always @(negedge clock) begin
        if (reset && lsu_to_ws_valid_o && ws_allowin_i) begin
            if (sb.size() == 0) begin
                chk("sb_empty", 64'(sb.size()), 64'd1);
            end else begin
                mon_e = sb.pop_front();
                chk("wb_wdata", 64'(ws_wdata_o), 64'(mon_e.wdata));
                chk("wb_wreg", 64'(ws_wreg_o), 64'(mon_e.wreg));
                chk("wb_pc", 64'(ws_pc_o), 64'(mon_e.pc));
            end
        end
    end

    initial begin
        #2;
        chk("rst_tows", 64'(lsu_to_ws_valid_o), 64'd0);
        chk("rst_reqv", 64'(mem_req_valid_o), 64'd0);
        chk("rst_wdata", 64'(ws_wdata_o), 64'd0);
        chk("rst_fwd", 64'(ls_to_ds_forward_bus_o), 64'd0);
        chk("rst_allowin", 64'(lsu_allowin_o), 64'd1);
        tick();
        tick();
        reset = 1'b1;

        // Non-memory op completes the cycle after acceptance.
        drive(LD_NONE, ST_NONE, 32'h1234, 32'h0, 1'b1, 5'd5, 32'h100);
        push(32'h1234, 5'd5, 32'h100);
        wait_accept("nm");
        chk("nm_tows", 64'(lsu_to_ws_valid_o), 64'd1);
        chk("nm_wdata", 64'(ws_wdata_o), 64'h1234);
        chk("nm_reqv", 64'(mem_req_valid_o), 64'd0);
        chk("nm_fwd", 64'(ls_to_ds_forward_bus_o), 64'({1'b0, 1'b1, 5'd5, 32'h1234}));
        tick();
        chk("nm_drain", 64'(lsu_to_ws_valid_o), 64'd0);

        // LB, memory ready and responding immediately.
        mem_resp_valid_i = 1'b1;
        mem_resp_rdata_i = 32'h80FFFFFF;
        drive(LD_LB, ST_NONE, 32'h80000003, 32'h0, 1'b1, 5'd7, 32'h104);
        push(32'hFFFFFF80, 5'd7, 32'h104);
        wait_accept("lb");
        chk("lb_reqv", 64'(mem_req_valid_o), 64'd1);
        chk("lb_addr", 64'(mem_req_addr_o), 64'h80000000);
        chk("lb_wen", 64'(mem_req_wen_o), 64'd0);
        chk("lb_stall", 64'(ls_to_ds_forward_bus_o[38]), 64'd1);
        chk("lb_tows_req", 64'(lsu_to_ws_valid_o), 64'd0);
        tick();
        chk("lb_tows_wait", 64'(lsu_to_ws_valid_o), 64'd0);
        chk("lb_reqv_wait", 64'(mem_req_valid_o), 64'd0);
        tick();
        chk("lb_lat3", 64'(lsu_to_ws_valid_o), 64'd1);
        chk("lb_wdata", 64'(ws_wdata_o), 64'hFFFFFF80);
        chk("lb_stall_done", 64'(ls_to_ds_forward_bus_o[38]), 64'd0);
        tick();
        chk("lb_drain", 64'(lsu_to_ws_valid_o), 64'd0);

        // SH lane placement.
        drive(LD_NONE, ST_SH, 32'h80000002, 32'hABCD1234, 1'b0, 5'd0, 32'h108);
        push(32'h80000002, 5'd0, 32'h108);
        wait_accept("sh");
        chk("sh_wstrb", 64'(mem_req_wstrb_o), 64'b1100);
        chk("sh_wdata", 64'(mem_req_wdata_o), 64'h12341234);
        chk("sh_addr", 64'(mem_req_addr_o), 64'h80000000);
        chk("sh_wen", 64'(mem_req_wen_o), 64'd1);
        chk("sh_stall", 64'(ls_to_ds_forward_bus_o[38]), 64'd0);
        tick();
        tick();
        chk("sh_tows", 64'(lsu_to_ws_valid_o), 64'd1);
        tick();

        // LW with mem_req_ready_i low for 4 cycles; a stray response in REQ is ignored.
        mem_req_ready_i  = 1'b0;
        mem_resp_rdata_i = 32'hBAD0BAD0;
        drive(LD_LW, ST_NONE, 32'h80000010, 32'h0, 1'b1, 5'd9, 32'h10C);
        push(32'hDEADBEEF, 5'd9, 32'h10C);
        wait_accept("lw");
        for (int i = 0; i < 4; i++) begin
            chk("stl_addr", 64'(mem_req_addr_o), 64'h80000010);
            chk("stl_reqv", 64'(mem_req_valid_o), 64'd1);
            chk("stl_allowin", 64'(lsu_allowin_o), 64'd0);
            chk("stl_fwd_stall", 64'(ls_to_ds_forward_bus_o[38]), 64'd1);
            tick();
        end
        mem_req_ready_i  = 1'b1;
        mem_resp_rdata_i = 32'hDEADBEEF;
        tick();
        chk("stl_wait_tows", 64'(lsu_to_ws_valid_o), 64'd0);
        tick();
        chk("stl_tows", 64'(lsu_to_ws_valid_o), 64'd1);
        chk("stl_wdata", 64'(ws_wdata_o), 64'hDEADBEEF);
        tick();

        // Back-to-back loads with WB stalled while the first sits in DONE.
        ws_allowin_i     = 1'b0;
        mem_resp_rdata_i = 32'h80010000;
        drive(LD_LHU, ST_NONE, 32'h80000002, 32'h0, 1'b1, 5'd10, 32'h110);
        push(32'h00008001, 5'd10, 32'h110);
        wait_accept("lhu");
        tick();
        tick();
        drive(LD_LH, ST_NONE, 32'h80000000, 32'h0, 1'b1, 5'd11, 32'h114);
        push(32'hFFFFF00F, 5'd11, 32'h114);
        mem_resp_rdata_i = 32'h0000F00F;
        for (int i = 0; i < 3; i++) begin
            chk("b2b_allowin", 64'(lsu_allowin_o), 64'd0);
            chk("b2b_tows", 64'(lsu_to_ws_valid_o), 64'd1);
            chk("b2b_hold", 64'(ws_wdata_o), 64'h8001);
            tick();
        end
        ws_allowin_i = 1'b1;
        #1;
        chk("b2b_allowin_up", 64'(lsu_allowin_o), 64'd1);
        tick();
        es_to_lsu_valid_i = 1'b0;
        chk("b2b_req", 64'(mem_req_valid_o), 64'd1);
        chk("b2b_addr", 64'(mem_req_addr_o), 64'h80000000);
        tick();
        tick();
        chk("b2b_tows2", 64'(lsu_to_ws_valid_o), 64'd1);
        chk("b2b_wdata2", 64'(ws_wdata_o), 64'hFFFFF00F);
        tick();

        // Reset while in WAIT, followed by a late response.
        mem_resp_valid_i = 1'b0;
        drive(LD_LW, ST_NONE, 32'h80000020, 32'h0, 1'b1, 5'd12, 32'h118);
        push(32'h0, 5'd12, 32'h118);
        wait_accept("rw");
        tick();
        chk("rw_tows", 64'(lsu_to_ws_valid_o), 64'd0);
        chk("rw_reqv", 64'(mem_req_valid_o), 64'd0);
        #2;
        reset = 1'b0;
        #1;
        sb.delete();
        chk("rw_rst_tows", 64'(lsu_to_ws_valid_o), 64'd0);
        chk("rw_rst_reqv", 64'(mem_req_valid_o), 64'd0);
        chk("rw_rst_pc", 64'(ws_pc_o), 64'd0);
        chk("rw_rst_fwd", 64'(ls_to_ds_forward_bus_o), 64'd0);
        mem_resp_valid_i = 1'b1;
        mem_resp_rdata_i = 32'h12345678;
        tick();
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("late_tows", 64'(lsu_to_ws_valid_o), 64'd0);
            chk("late_wdata", 64'(ws_wdata_o), 64'd0);
            chk("late_fwd", 64'(ls_to_ds_forward_bus_o), 64'd0);
            chk("late_idle", 64'(lsu_allowin_o), 64'd1);
        end
        mem_resp_valid_i = 1'b0;

        drive(LD_NONE, ST_NONE, 32'h55AA, 32'h0, 1'b1, 5'd3, 32'h11C);
        push(32'h55AA, 5'd3, 32'h11C);
        wait_accept("post");
        chk("post_tows", 64'(lsu_to_ws_valid_o), 64'd1);
        tick();
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
